button_led_ctrl: RTL and testbench

Parametrised push-button and RGB-LED controller for the board-level sample tops.
- Synchronises and debounces NUM_BUTTONS active-low push buttons, and reports debounced level plus one-cycle press/release pulses.
- Runs a colour-mode state machine and a brightness register driven by the buttons.
- Drives the three active-low LED pins through a shared PWM generator.

---
 rtl/button_led_ctrl.sv | 149 ++++++++++++++
 tb/tb_button_led_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_led_ctrl.sv
// Push-button debouncer plus colour-mode/brightness control driving three
// active-low LED pins through a shared PWM generator.
module button_led_ctrl #(
  parameter int unsigned NUM_BUTTONS     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned PWM_WIDTH       = 8,
  parameter int unsigned BRIGHT_STEP     = 16,
  parameter int unsigned BRIGHT_RESET    = 128
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] push_button_n,
  output logic [NUM_BUTTONS-1:0] button_state,
  output logic [NUM_BUTTONS-1:0] button_press,
  output logic [NUM_BUTTONS-1:0] button_release,
  output logic [2:0]             mode,
  output logic [PWM_WIDTH-1:0]   brightness,
  output logic                   led_red_n,
  output logic                   led_green_n,
  output logic                   led_blue_n
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW    = PWM_WIDTH + 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0]    STEP_W     = BW'(BRIGHT_STEP);
  localparam logic [BW-1:0]    BRIGHT_MAX = {1'b0, {PWM_WIDTH{1'b1}}};

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_WHITE = 3'd4
  } mode_e;

  logic [NUM_BUTTONS-1:0] sync_1;
  logic [NUM_BUTTONS-1:0] sync_2;
  logic [NUM_BUTTONS-1:0] synced;
  logic [CNT_W-1:0]       db_cnt [NUM_BUTTONS];

  mode_e                  mode_q;
  logic [PWM_WIDTH-1:0]   pwm_cnt;
  logic                   inc_press;
  logic                   dec_press;
  logic [BW-1:0]          bright_w;
  logic [BW-1:0]          bright_up;
  logic                   pwm_on;
  logic                   sel_red;
  logic                   sel_green;
  logic                   sel_blue;

  assign synced = ~sync_2;

  // Two-flop synchroniser followed by a per-button stability counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync_1         <= '1;
      sync_2         <= '1;
      button_state   <= '0;
      button_press   <= '0;
      button_release <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_1 <= push_button_n;
      sync_2 <= sync_1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        button_press[i]   <= 1'b0;
        button_release[i] <= 1'b0;
        if (synced[i] == button_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db_cnt[i]         <= '0;
          button_state[i]   <= synced[i];
          button_press[i]   <= synced[i];
          button_release[i] <= ~synced[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign inc_press = button_press[1];

  generate
    if (NUM_BUTTONS >= 3) begin : g_dec
      assign dec_press = button_press[2];
    end else begin : g_no_dec
      assign dec_press = 1'b0;
    end
  endgenerate

  // Colour-mode state machine; unused codes fall back to OFF.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q <= MODE_OFF;
    end else begin
      case (mode_q)
        MODE_OFF:   if (button_press[0]) mode_q <= MODE_RED;
        MODE_RED:   if (button_press[0]) mode_q <= MODE_GREEN;
        MODE_GREEN: if (button_press[0]) mode_q <= MODE_BLUE;
        MODE_BLUE:  if (button_press[0]) mode_q <= MODE_WHITE;
        MODE_WHITE: if (button_press[0]) mode_q <= MODE_OFF;
        default:    mode_q <= MODE_OFF;
      endcase
    end
  end

  assign mode = mode_q;

  // Saturating brightness arithmetic, one bit wider than the register.
  assign bright_w  = {1'b0, brightness};
  assign bright_up = bright_w + STEP_W;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      brightness <= PWM_WIDTH'(BRIGHT_RESET);
    end else if (inc_press && !dec_press) begin
      brightness <= (bright_up > BRIGHT_MAX) ? '1 : bright_up[PWM_WIDTH-1:0];
    end else if (dec_press && !inc_press) begin
      brightness <= (bright_w < STEP_W) ? '0 : PWM_WIDTH'(bright_w - STEP_W);
    end
  end

  assign pwm_on    = (pwm_cnt < brightness);
  assign sel_red   = (mode_q == MODE_RED)   || (mode_q == MODE_WHITE);
  assign sel_green = (mode_q == MODE_GREEN) || (mode_q == MODE_WHITE);
  assign sel_blue  = (mode_q == MODE_BLUE)  || (mode_q == MODE_WHITE);

  // Free-running PWM counter and registered LED pins.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pwm_cnt     <= '0;
      led_red_n   <= 1'b1;
      led_green_n <= 1'b1;
      led_blue_n  <= 1'b1;
    end else begin
      pwm_cnt     <= pwm_cnt + PWM_WIDTH'(1);
      led_red_n   <= ~(pwm_on & sel_red);
      led_green_n <= ~(pwm_on & sel_green);
      led_blue_n  <= ~(pwm_on & sel_blue);
    end
  end

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl: debounce latency, bounce rejection,
// mode wrap, brightness saturation, PWM duty and mid-operation reset.
module tb_button_led_ctrl;

  localparam int unsigned NB = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [NB-1:0] push_button_n;
  logic [NB-1:0] button_state;
  logic [NB-1:0] button_press;
  logic [NB-1:0] button_release;
  logic [2:0]    mode;
  logic [3:0]    brightness;
  logic          led_red_n;
  logic          led_green_n;
  logic          led_blue_n;

  int checks   = 0;
  int failures = 0;
  int press_cnt [NB];
  int rel_cnt   [NB];

  localparam int EXP_MODE [5] = '{1, 2, 3, 4, 0};
  localparam int EXP_R    [5] = '{8, 0, 0, 8, 0};
  localparam int EXP_G    [5] = '{0, 8, 0, 8, 0};
  localparam int EXP_B    [5] = '{0, 0, 8, 8, 0};
  localparam int EXP_UP   [3] = '{12, 15, 15};
  localparam int EXP_DN   [5] = '{11, 7, 3, 0, 0};

  button_led_ctrl #(
    .NUM_BUTTONS     (3),
    .DEBOUNCE_CYCLES (4),
    .PWM_WIDTH       (4),
    .BRIGHT_STEP     (4),
    .BRIGHT_RESET    (8)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .push_button_n  (push_button_n),
    .button_state   (button_state),
    .button_press   (button_press),
    .button_release (button_release),
    .mode           (mode),
    .brightness     (brightness),
    .led_red_n      (led_red_n),
    .led_green_n    (led_green_n),
    .led_blue_n     (led_blue_n)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled shortly after each rising edge.
  always @(posedge clock) begin
    #2;
    for (int i = 0; i < NB; i++) begin
      if (button_press[i] === 1'b1)   press_cnt[i]++;
      if (button_release[i] === 1'b1) rel_cnt[i]++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0;
      rel_cnt[i]   = 0;
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    push_button_n = 3'b111;
    step(2);
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic wait_pulse(input bit rel, input int b, output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if ((rel ? button_release[b] : button_press[b]) === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic press_mask(input logic [NB-1:0] m, input int b);
    int lat;
    push_button_n = push_button_n & ~m;
    wait_pulse(1'b0, b, lat);
    check_eq("press_latency", lat, 6);
    push_button_n = push_button_n | m;
    wait_pulse(1'b1, b, lat);
    check_eq("release_latency", lat, 6);
    step();
  endtask

  task automatic count_low(input int n, output int r, output int g, output int bl);
    r = 0; g = 0; bl = 0;
    repeat (n) begin
      step();
      if (led_red_n == 1'b0)   r++;
      if (led_green_n == 1'b0) g++;
      if (led_blue_n == 1'b0)  bl++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int r, g, bl;
    bit found;
    logic prev;

    clear_counts();

    // Reset with all buttons held down.
    reset_n       = 1'b0;
    push_button_n = 3'b000;
    step(3);
    check_eq("rst_leds", {led_red_n, led_green_n, led_blue_n}, 3'b111);
    check_eq("rst_mode", mode, 0);
    check_eq("rst_brightness", brightness, 8);
    check_eq("rst_state", button_state, 0);
    check_eq("rst_press", button_press, 0);
    check_eq("rst_release", button_release, 0);
    reset_n = 1'b1;
    wait_pulse(1'b0, 0, lat);
    check_eq("held_press_latency", lat, 6);
    check_eq("held_press_all", button_press, 3'b111);
    step();
    check_eq("held_mode", mode, 1);
    check_eq("held_bright_both", brightness, 8);
    push_button_n = 3'b111;
    step(10);

    // Bounce on button 0.
    do_reset();
    clear_counts();
    push_button_n[0] = 1'b0; step(3);
    push_button_n[0] = 1'b1; step(1);
    push_button_n[0] = 1'b0; step(2);
    push_button_n[0] = 1'b1; step(1);
    push_button_n[0] = 1'b0;
    wait_pulse(1'b0, 0, lat);
    check_eq("bounce_latency", lat, 6);
    step();
    check_eq("bounce_press_count", press_cnt[0], 1);
    check_eq("bounce_mode", mode, 1);
    clear_counts();
    push_button_n[0] = 1'b1;
    wait_pulse(1'b1, 0, lat);
    check_eq("bounce_rel_latency", lat, 6);
    step();
    check_eq("bounce_rel_count", rel_cnt[0], 1);
    check_eq("bounce_state", button_state, 0);

    // Mode wrap and LED selection at half duty.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press_mask(3'b001, 0);
      check_eq("wrap_mode", mode, EXP_MODE[i]);
      count_low(16, r, g, bl);
      check_eq("wrap_red_low", r, EXP_R[i]);
      check_eq("wrap_green_low", g, EXP_G[i]);
      check_eq("wrap_blue_low", bl, EXP_B[i]);
    end

    // Brightness saturation at both ends, then simultaneous up/down.
    for (int i = 0; i < 3; i++) begin
      press_mask(3'b010, 1);
      check_eq("sat_up", brightness, EXP_UP[i]);
    end
    for (int i = 0; i < 5; i++) begin
      press_mask(3'b100, 2);
      check_eq("sat_down", brightness, EXP_DN[i]);
    end
    press_mask(3'b010, 1);
    check_eq("up_from_zero", brightness, 4);
    press_mask(3'b110, 1);
    check_eq("up_down_same_cycle", brightness, 4);
    check_eq("up_down_mode", mode, 0);

    // PWM duty in RED.
    do_reset();
    press_mask(3'b001, 0);
    press_mask(3'b010, 1);
    check_eq("pwm_bright", brightness, 12);
    for (int w = 0; w < 2; w++) begin
      count_low(16, r, g, bl);
      check_eq("pwm_red_low", r, 12);
      check_eq("pwm_green_low", g, 0);
      check_eq("pwm_blue_low", bl, 0);
    end
    for (int i = 0; i < 3; i++) press_mask(3'b100, 2);
    check_eq("pwm_bright_zero", brightness, 0);
    count_low(32, r, g, bl);
    check_eq("pwm_zero_red_low", r, 0);

    // Reset during a lit LED with a debounce half-way done.
    do_reset();
    press_mask(3'b001, 0);
    found = 1'b0;
    prev  = led_red_n;
    for (int k = 0; k < 40; k++) begin
      step();
      if (prev == 1'b1 && led_red_n == 1'b0) begin
        found = 1'b1;
        break;
      end
      prev = led_red_n;
    end
    check_eq("lit_phase_found", found, 1);
    push_button_n[0] = 1'b0;
    step(4);
    check_eq("pre_reset_led", led_red_n, 0);
    clear_counts();
    reset_n = 1'b0;
    step();
    check_eq("mid_rst_leds", {led_red_n, led_green_n, led_blue_n}, 3'b111);
    check_eq("mid_rst_mode", mode, 0);
    check_eq("mid_rst_brightness", brightness, 8);
    check_eq("mid_rst_state", button_state, 0);
    reset_n = 1'b1;
    step(4);
    check_eq("mid_rst_no_press", press_cnt[0], 0);
    check_eq("mid_rst_state_after", button_state, 0);
    push_button_n = 3'b111;
    step(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
